// File: rtl/aes_byte_tx.sv
// Byte-serial block output: byte 0 first, optional NBYTES header byte; first byte 1 cycle after accept.
// Double-buffered (cur + pend) so blocks stream back-to-back; out_data/out_last hold while out_ready is low.
module aes_byte_tx #(
  parameter int NBYTES = 16,
  parameter int HDR_EN = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  blk_valid,
  output logic                  blk_ready,
  input  logic [8*NBYTES-1:0]   blk_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  blk_done
);

  localparam int              CW       = $clog2(NBYTES + 1);
  localparam logic [CW-1:0]   LAST_IDX = CW'(NBYTES - 1);
  localparam logic [7:0]      HDR_BYTE = 8'(NBYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    SEND = 2'd2
  } state_t;

  localparam state_t FIRST = (HDR_EN != 0) ? HDR : SEND;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [8*NBYTES-1:0]   r_cur;
  logic [8*NBYTES-1:0]   r_pend;
  logic                  r_pend_full;
  logic [CW-1:0]         r_cnt;
  logic                  r_done;

  logic w_xfer;
  logic w_acc;
  logic w_at_last;
  logic w_final;
  logic w_load_in;
  logic w_load_pend;
  logic w_to_pend;
  logic w_shift;

  assign out_valid = (r_state != IDLE);
  assign blk_ready = !r_pend_full;
  assign busy      = (r_state != IDLE) || r_pend_full;
  assign blk_done  = r_done;
  assign out_last  = w_at_last;

  assign w_xfer    = out_valid && out_ready;
  assign w_acc     = blk_valid && !r_pend_full;
  assign w_at_last = (r_state == SEND) && (r_cnt == LAST_IDX);
  assign w_final   = w_at_last && w_xfer;

  always_comb begin
    out_data = 8'h00;
    case (r_state)
      HDR:     out_data = HDR_BYTE;
      SEND:    out_data = r_cur[7:0];
      default: out_data = 8'h00;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_in   = 1'b0;
    w_load_pend = 1'b0;
    w_to_pend   = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_acc) begin
          w_load_in   = 1'b1;
          w_state_nxt = FIRST;
        end
      end
      HDR: begin
        w_to_pend = w_acc;
        if (w_xfer) begin
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        // Final byte: refill cur from pend first, else from a same-cycle accept.
        if (w_final) begin
          if (r_pend_full) begin
            w_load_pend = 1'b1;
            w_state_nxt = FIRST;
          end else if (w_acc) begin
            w_load_in   = 1'b1;
            w_state_nxt = FIRST;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_to_pend = w_acc;
          w_shift   = w_xfer;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cur       <= '0;
      r_pend      <= '0;
      r_pend_full <= 1'b0;
      r_cnt       <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_final;
      if (w_load_in) begin
        r_cur <= blk_data;
        r_cnt <= '0;
      end else if (w_load_pend) begin
        r_cur <= r_pend;
        r_cnt <= '0;
      end else if (w_shift) begin
        r_cur <= r_cur >> 8;
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_load_pend) begin
        r_pend_full <= 1'b0;
      end else if (w_to_pend) begin
        r_pend      <= blk_data;
        r_pend_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aes_byte_tx.sv
// Bench for aes_byte_tx: two instances (no header / header) checked against a byte-queue reference model.
module tb_aes_byte_tx;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } ent_t;

  logic         clk;
  logic         reset;
  logic         blk_valid [2];
  logic         blk_ready [2];
  logic [127:0] blk_data  [2];
  logic         out_valid [2];
  logic         out_ready [2];
  logic [7:0]   out_data  [2];
  logic         out_last  [2];
  logic         busy      [2];
  logic         blk_done  [2];

  int checks = 0;
  int errors = 0;

  aes_byte_tx #(.NBYTES(16), .HDR_EN(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .blk_valid(blk_valid[0]), .blk_ready(blk_ready[0]), .blk_data(blk_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .out_last(out_last[0]), .busy(busy[0]), .blk_done(blk_done[0])
  );

  aes_byte_tx #(.NBYTES(16), .HDR_EN(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .blk_valid(blk_valid[1]), .blk_ready(blk_ready[1]), .blk_data(blk_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .out_last(out_last[1]), .busy(busy[1]), .blk_done(blk_done[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] rand_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      blk_valid[d] = 1'b0;
      blk_data[d]  = '0;
      out_ready[d] = 1'b0;
    end
    #12;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (out_valid[d] !== 1'b0 || out_data[d] !== 8'h00 || out_last[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_out dut%0d got v=%b d=%h l=%b want 0/00/0", d, out_valid[d], out_data[d], out_last[d]);
      end
      checks++;
      if (busy[d] !== 1'b0 || blk_done[d] !== 1'b0 || blk_ready[d] !== 1'b1) begin
        errors++;
        $display("FAIL reset_ctl dut%0d got busy=%b done=%b rdy=%b want 0/0/1", d, busy[d], blk_done[d], blk_ready[d]);
      end
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single(input int d);
    logic [127:0] blk;
    int           n;
    logic [7:0]   exp_d;
    n = 16 + d;
    for (int k = 0; k < 16; k++) blk[8*k +: 8] = 8'(k);
    @(negedge clk);
    blk_data[d]  = blk;
    blk_valid[d] = 1'b1;
    out_ready[d] = 1'b1;
    for (int k = 1; k <= n + 2; k++) begin
      @(negedge clk);
      blk_valid[d] = 1'b0;
      if (k <= n) begin
        exp_d = (d == 1 && k == 1) ? 8'h10 : 8'(k - 1 - d);
        checks++;
        if (out_valid[d] !== 1'b1 || out_data[d] !== exp_d || out_last[d] !== (k == n)) begin
          errors++;
          $display("FAIL single dut%0d byte%0d got v=%b d=%h l=%b want 1/%h/%b", d, k, out_valid[d], out_data[d], out_last[d], exp_d, (k == n));
        end
        checks++;
        if (blk_done[d] !== 1'b0 || busy[d] !== 1'b1) begin
          errors++;
          $display("FAIL single_ctl dut%0d byte%0d got done=%b busy=%b want 0/1", d, k, blk_done[d], busy[d]);
        end
      end else begin
        checks++;
        if (blk_done[d] !== (k == n + 1) || out_valid[d] !== 1'b0 || busy[d] !== 1'b0) begin
          errors++;
          $display("FAIL single_end dut%0d cyc%0d got done=%b v=%b busy=%b want %b/0/0", d, k, blk_done[d], out_valid[d], busy[d], (k == n + 1));
        end
      end
    end
    out_ready[d] = 1'b0;
  endtask

  // Block B offered at the negedge that shows A's byte b_at-1; A's final transfer is on the 16th edge.
  task automatic test_back_to_back(input int b_at);
    logic [127:0] a, b;
    logic [7:0]   exp_d;
    logic         exp_v, exp_r;
    a = rand_blk();
    b = rand_blk();
    @(negedge clk);
    blk_data[0]  = a;
    blk_valid[0] = 1'b1;
    out_ready[0] = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      exp_v = (k <= 32);
      exp_r = !(b_at < 16 && k > b_at && k <= 16);
      exp_d = (k <= 16) ? a[8*(k-1) +: 8] : ((k <= 32) ? b[8*(k-17) +: 8] : 8'h00);
      checks++;
      if (out_valid[0] !== exp_v || busy[0] !== exp_v || blk_ready[0] !== exp_r || blk_done[0] !== (k == 17 || k == 33)) begin
        errors++;
        $display("FAIL b2b_%0d_ctl cyc%0d got v=%b busy=%b rdy=%b done=%b want %b/%b/%b/%b", b_at, k,
                 out_valid[0], busy[0], blk_ready[0], blk_done[0], exp_v, exp_v, exp_r, (k == 17 || k == 33));
      end
      if (exp_v) begin
        checks++;
        if (out_data[0] !== exp_d || out_last[0] !== (k == 16 || k == 32)) begin
          errors++;
          $display("FAIL b2b_%0d_data cyc%0d got d=%h l=%b want %h/%b", b_at, k, out_data[0], out_last[0], exp_d, (k == 16 || k == 32));
        end
      end
      if (k == b_at) begin
        blk_data[0]  = b;
        blk_valid[0] = 1'b1;
      end else begin
        blk_valid[0] = 1'b0;
      end
    end
    out_ready[0] = 1'b0;
  endtask

  // mode 0: out_ready cycles 1,0,0,1; mode 1: random out_ready.
  task automatic test_stream(input int d, input int mode, input int nblk);
    ent_t         q[$];
    ent_t         e;
    int           nb, sent;
    logic         done_exp, stall, fin, rdy, vld, xfer, acc, finished;
    logic [7:0]   pd;
    logic         pl;
    logic [127:0] blk;
    nb = 0; sent = 0; done_exp = 1'b0; stall = 1'b0; finished = 1'b0; pd = '0; pl = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      checks++;
      if (out_valid[d] !== (q.size() != 0) || busy[d] !== (q.size() != 0) ||
          blk_ready[d] !== (nb < 2) || blk_done[d] !== done_exp) begin
        errors++;
        $display("FAIL stream%0d_ctl dut%0d cyc%0d got v=%b busy=%b rdy=%b done=%b want %b/%b/%b/%b", mode, d, cyc,
                 out_valid[d], busy[d], blk_ready[d], blk_done[d], (q.size() != 0), (q.size() != 0), (nb < 2), done_exp);
      end
      if (q.size() != 0) begin
        checks++;
        if (out_data[d] !== q[0].d || out_last[d] !== q[0].l) begin
          errors++;
          $display("FAIL stream%0d_data dut%0d cyc%0d got d=%h l=%b want %h/%b", mode, d, cyc, out_data[d], out_last[d], q[0].d, q[0].l);
        end
      end
      if (stall) begin
        checks++;
        if (out_data[d] !== pd || out_last[d] !== pl) begin
          errors++;
          $display("FAIL stream%0d_stable dut%0d cyc%0d got d=%h l=%b want %h/%b", mode, d, cyc, out_data[d], out_last[d], pd, pl);
        end
      end
      if (sent == nblk && q.size() == 0 && !done_exp) begin
        finished = 1'b1;
        break;
      end
      rdy = (mode == 0) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'($urandom_range(0, 1));
      vld = (sent < nblk) && ($urandom_range(0, 2) != 0);
      blk = rand_blk();
      out_ready[d] = rdy;
      blk_valid[d] = vld;
      blk_data[d]  = blk;
      xfer  = (q.size() != 0) && rdy;
      acc   = vld && (nb < 2);
      stall = (q.size() != 0) && !rdy;
      fin   = 1'b0;
      if (q.size() != 0) begin
        pd = q[0].d;
        pl = q[0].l;
      end
      if (xfer) begin
        fin = q[0].l;
        if (fin) nb--;
        void'(q.pop_front());
      end
      if (acc) begin
        if (d == 1) begin
          e.d = 8'h10; e.l = 1'b0;
          q.push_back(e);
        end
        for (int k = 0; k < 16; k++) begin
          e.d = blk[8*k +: 8]; e.l = (k == 15);
          q.push_back(e);
        end
        nb++;
        sent++;
      end
      done_exp = fin;
    end
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL stream%0d_timeout dut%0d got sent=%0d left=%0d want all %0d drained", mode, d, sent, q.size(), nblk);
    end
    blk_valid[0] = 1'b0; blk_valid[1] = 1'b0;
    out_ready[0] = 1'b0; out_ready[1] = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [127:0] a;
    a = rand_blk();
    @(negedge clk);
    blk_data[0]  = a;
    blk_valid[0] = 1'b1;
    out_ready[0] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      blk_valid[0] = 1'b0;
      checks++;
      if (out_valid[0] !== 1'b1 || out_data[0] !== a[8*(k-1) +: 8]) begin
        errors++;
        $display("FAIL rstmid_pre byte%0d got v=%b d=%h want 1/%h", k - 1, out_valid[0], out_data[0], a[8*(k-1) +: 8]);
      end
    end
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid[0] !== 1'b0 || out_data[0] !== 8'h00 || out_last[0] !== 1'b0 ||
        busy[0] !== 1'b0 || blk_done[0] !== 1'b0 || blk_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_async got v=%b d=%h l=%b busy=%b done=%b rdy=%b want 0/00/0/0/0/1",
               out_valid[0], out_data[0], out_last[0], busy[0], blk_done[0], blk_ready[0]);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    checks++;
    if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_release got v=%b busy=%b want 0/0", out_valid[0], busy[0]);
    end
    blk_data[0]  = {16{8'hAA}};
    blk_valid[0] = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      blk_valid[0] = 1'b0;
      checks++;
      if (k <= 16) begin
        if (out_valid[0] !== 1'b1 || out_data[0] !== 8'hAA || out_last[0] !== (k == 16)) begin
          errors++;
          $display("FAIL rstmid_new byte%0d got v=%b d=%h l=%b want 1/aa/%b", k - 1, out_valid[0], out_data[0], out_last[0], (k == 16));
        end
      end else if (out_valid[0] !== 1'b0 || blk_done[0] !== 1'b1) begin
        errors++;
        $display("FAIL rstmid_end got v=%b done=%b want 0/1", out_valid[0], blk_done[0]);
      end
    end
    out_ready[0] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single(0);
    test_single(1);
    test_back_to_back(4);
    test_back_to_back(16);
    test_stream(0, 0, 6);
    test_stream(1, 0, 5);
    test_stream(1, 1, 6);
    test_stream(0, 1, 8);
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
